// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares one single-port Block RAM between NUM_CH requesters. One channel is
// granted per cycle by a round-robin scan that starts at the priority pointer.
// The winner's address, write data and byte enables drive the BRAM port.
// Granted reads are tracked by a RD_LAT-deep tag pipeline, so the read data
// can be returned to its originating channel with a one-hot valid pulse.
//
// Parameters:
//   NUM_CH     number of requesting channels (2..16)
//   DATA_BITW  data width in bits (multiple of 8)
//   ADDR_BITW  byte-address width in bits
//   RD_LAT     BRAM read latency in cycles (1 or 2)
//
// Ports:
//   Clk_CI        clock for all logic and for the BRAM port
//   Rst_RBI       synchronous active-low reset
//   Req_SI        per-channel request
//   Gnt_SO        one-hot grant, combinational from Req_SI
//   Addr_DI       per-channel byte address, channel c at [c*ADDR_BITW +: ADDR_BITW]
//   Wr_DI         per-channel write data,   channel c at [c*DATA_BITW +: DATA_BITW]
//   WrEn_SI       per-channel byte enables; all-zero means read
//   Lock_SI       per-channel lock (only with BRAM_PORT_ARBITER_LOCK_EN)
//   Rd_DO         read data, shared by all channels
//   RdVal_SO      one-hot read-data valid
//   Bram_Rst_RO   BRAM output-register reset, active high
//   Bram_En_SO    BRAM enable
//   Bram_Addr_DO  BRAM byte address
//   Bram_Wr_DO    BRAM write data
//   Bram_WrEn_SO  BRAM byte write enable
//   Bram_Rd_DI    BRAM read data
//
// Optional feature: define BRAM_PORT_ARBITER_LOCK_EN to add Lock_SI. A channel
// that was granted last cycle and still holds Req_SI and Lock_SI is granted
// again, ahead of the round-robin scan.
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DATA_BITW = 32,
  parameter int ADDR_BITW = 32,
  parameter int RD_LAT    = 1
) (
  input  logic                            Clk_CI,
  input  logic                            Rst_RBI,
  input  logic [NUM_CH-1:0]               Req_SI,
  output logic [NUM_CH-1:0]               Gnt_SO,
  input  logic [NUM_CH*ADDR_BITW-1:0]     Addr_DI,
  input  logic [NUM_CH*DATA_BITW-1:0]     Wr_DI,
  input  logic [NUM_CH*(DATA_BITW/8)-1:0] WrEn_SI,
`ifdef BRAM_PORT_ARBITER_LOCK_EN
  input  logic [NUM_CH-1:0]               Lock_SI,
`endif
  output logic [DATA_BITW-1:0]            Rd_DO,
  output logic [NUM_CH-1:0]               RdVal_SO,
  output logic                            Bram_Rst_RO,
  output logic                            Bram_En_SO,
  output logic [ADDR_BITW-1:0]            Bram_Addr_DO,
  output logic [DATA_BITW-1:0]            Bram_Wr_DO,
  output logic [DATA_BITW/8-1:0]          Bram_WrEn_SO,
  input  logic [DATA_BITW-1:0]            Bram_Rd_DI
);

  localparam int IDX_BITW = $clog2(NUM_CH);
  localparam int BE_BITW  = DATA_BITW / 8;

  logic [IDX_BITW-1:0] prio_q, prio_d;   // round-robin pointer (highest priority)
  logic                win_vld;
  logic [IDX_BITW-1:0] win_idx;
  logic [IDX_BITW-1:0] cand;
  logic                is_rd;

  logic [RD_LAT-1:0]   tag_vld_q;
  logic [IDX_BITW-1:0] tag_ch_q [RD_LAT];

`ifdef BRAM_PORT_ARBITER_LOCK_EN
  logic                lock_vld_q;       // a grant happened last cycle
  logic [IDX_BITW-1:0] lock_ch_q;        // channel granted last cycle
  logic                lock_hit;

  assign lock_hit = lock_vld_q & Req_SI[lock_ch_q] & Lock_SI[lock_ch_q];
`endif

  // Winner selection: first requester at or above prio_q, wrapping around.
  always_comb begin : arbitrate
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = IDX_BITW'((int'(prio_q) + i) % NUM_CH);
      if (!win_vld && Req_SI[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
`ifdef BRAM_PORT_ARBITER_LOCK_EN
    // A held lock overrides the scan; the pointer then stays at holder+1.
    if (lock_hit) begin
      win_vld = 1'b1;
      win_idx = lock_ch_q;
    end
`endif
    if (!Rst_RBI) win_vld = 1'b0;
  end

  always_comb begin : next_prio
    prio_d = prio_q;
    if (win_vld) begin
      if (win_idx == IDX_BITW'(NUM_CH - 1)) prio_d = '0;
      else                                  prio_d = win_idx + 1'b1;
    end
  end

  // Port mux: everything reads as zero when nothing is granted.
  always_comb begin : port_mux
    Gnt_SO       = '0;
    Bram_Addr_DO = '0;
    Bram_Wr_DO   = '0;
    Bram_WrEn_SO = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (win_vld && win_idx == IDX_BITW'(c)) begin
        Gnt_SO[c]    = 1'b1;
        Bram_Addr_DO = Addr_DI[c*ADDR_BITW +: ADDR_BITW];
        Bram_Wr_DO   = Wr_DI[c*DATA_BITW +: DATA_BITW];
        Bram_WrEn_SO = WrEn_SI[c*BE_BITW +: BE_BITW];
      end
    end
  end

  assign is_rd       = win_vld && (Bram_WrEn_SO == '0);
  assign Bram_En_SO  = Rst_RBI & (|Req_SI);
  assign Bram_Rst_RO = ~Rst_RBI;
  assign Rd_DO       = Bram_Rd_DI;

  // Control state: pointer and tag valid bits.
  always_ff @(posedge Clk_CI) begin : ctrl_regs
    if (!Rst_RBI) begin
      prio_q    <= '0;
      tag_vld_q <= '0;
    end else begin
      prio_q       <= prio_d;
      tag_vld_q[0] <= is_rd;
      for (int s = 1; s < RD_LAT; s++) tag_vld_q[s] <= tag_vld_q[s-1];
    end
  end

  // NOTE: the channel index payload is never reset; it is only looked at
  // when the matching valid bit is set, and the valid bits are reset.
  always_ff @(posedge Clk_CI) begin : tag_payload
    tag_ch_q[0] <= win_idx;
    for (int s = 1; s < RD_LAT; s++) tag_ch_q[s] <= tag_ch_q[s-1];
  end

`ifdef BRAM_PORT_ARBITER_LOCK_EN
  always_ff @(posedge Clk_CI) begin : lock_regs
    if (!Rst_RBI) begin
      lock_vld_q <= 1'b0;
      lock_ch_q  <= '0;
    end else begin
      lock_vld_q <= win_vld;
      lock_ch_q  <= win_idx;
    end
  end
`endif

  // Read-data valid: decode of the last tag stage, silenced during reset.
  always_comb begin : rd_valid
    RdVal_SO = '0;
    if (Rst_RBI && tag_vld_q[RD_LAT-1]) RdVal_SO[tag_ch_q[RD_LAT-1]] = 1'b1;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Directed bench for bram_port_arbiter (NUM_CH=4, DATA_BITW=32, ADDR_BITW=32,
// RD_LAT=2) attached to a small behavioural BRAM with a two-cycle read path.
// Inputs change on the falling edge; outputs are checked 1 ns later.
// The lock sequence is included when BRAM_PORT_ARBITER_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [3:0]   gnt;
  logic [127:0] addr_flat;
  logic [127:0] wr_flat;
  logic [15:0]  we_flat;
`ifdef BRAM_PORT_ARBITER_LOCK_EN
  logic [3:0]   lock;
`endif
  logic [31:0]  rd;
  logic [3:0]   rdval;
  logic         bram_rst;
  logic         bram_en;
  logic [31:0]  bram_addr;
  logic [31:0]  bram_wr;
  logic [3:0]   bram_we;
  logic [31:0]  bram_rd;

  int checks   = 0;
  int failures = 0;

  bram_port_arbiter #(
    .NUM_CH(4), .DATA_BITW(32), .ADDR_BITW(32), .RD_LAT(2)
  ) dut (
    .Clk_CI       (clk),
    .Rst_RBI      (rst_n),
    .Req_SI       (req),
    .Gnt_SO       (gnt),
    .Addr_DI      (addr_flat),
    .Wr_DI        (wr_flat),
    .WrEn_SI      (we_flat),
`ifdef BRAM_PORT_ARBITER_LOCK_EN
    .Lock_SI      (lock),
`endif
    .Rd_DO        (rd),
    .RdVal_SO     (rdval),
    .Bram_Rst_RO  (bram_rst),
    .Bram_En_SO   (bram_en),
    .Bram_Addr_DO (bram_addr),
    .Bram_Wr_DO   (bram_wr),
    .Bram_WrEn_SO (bram_we),
    .Bram_Rd_DI   (bram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM: 64 words, byte writes, two registered read stages.
  logic [31:0] mem [64];
  logic [31:0] rd1_q, rd2_q;

  always_ff @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr[7:2]][b*8 +: 8] <= bram_wr[b*8 +: 8];
      rd1_q <= mem[bram_addr[7:2]];
    end
    rd2_q <= rd1_q;
  end
  assign bram_rd = rd2_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] w);
    addr_flat[ch*32 +: 32] = a;
    wr_flat[ch*32 +: 32]   = d;
    we_flat[ch*4 +: 4]     = w;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b1111;
    addr_flat = '0;
    wr_flat   = '0;
    we_flat   = '0;
`ifdef BRAM_PORT_ARBITER_LOCK_EN
    lock      = 4'b0000;
`endif

    // Reset with all channels requesting: everything quiet, BRAM reset high.
    @(negedge clk); #1;
    check("rst_gnt",      32'(gnt),       32'h0);
    check("rst_en",       32'(bram_en),   32'h0);
    check("rst_bram_rst", 32'(bram_rst),  32'h1);
    check("rst_rdval",    32'(rdval),     32'h0);
    check("rst_addr",     bram_addr,      32'h0);
    check("rst_we",       32'(bram_we),   32'h0);

    // Round robin with all four requesting: 0,1,2,3,0,1,2,3; each read
    // returns its valid two cycles after the grant.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) set_ch(c, 32'(c * 4), 32'h0, 4'h0);
      end
      #1;
      check("rr_gnt",   32'(gnt),   32'(1 << (i % 4)));
      check("rr_addr",  bram_addr,  32'((i % 4) * 4));
      check("rr_rdval", 32'(rdval), (i >= 2) ? 32'(1 << ((i - 2) % 4)) : 32'h0);
    end
    @(negedge clk); req = 4'b0000; #1;
    check("idle_gnt",   32'(gnt),     32'h0);
    check("idle_en",    32'(bram_en), 32'h0);
    check("idle_addr",  bram_addr,    32'h0);
    check("drain_rv2",  32'(rdval),   32'b0100);
    @(negedge clk); #1;
    check("drain_rv3",  32'(rdval),   32'b1000);
    @(negedge clk); #1;
    check("drain_none", 32'(rdval),   32'h0);

    // Ch2 full write, then ch1 reads it back.
    @(negedge clk); req = 4'b0100; set_ch(2, 32'h10, 32'hDEADBEEF, 4'hF); #1;
    check("wr_gnt",  32'(gnt),     32'b0100);
    check("wr_en",   32'(bram_en), 32'h1);
    check("wr_addr", bram_addr,    32'h10);
    check("wr_data", bram_wr,      32'hDEADBEEF);
    check("wr_we",   32'(bram_we), 32'hF);
    @(negedge clk); req = 4'b0010; set_ch(2, 0, 0, 4'h0); set_ch(1, 32'h10, 0, 4'h0); #1;
    check("rd_gnt",  32'(gnt),     32'b0010);
    check("rd_we",   32'(bram_we), 32'h0);
    @(negedge clk); req = 4'b0000; #1;
    check("wr_no_rdval", 32'(rdval), 32'h0);
    @(negedge clk); #1;
    check("rd_rdval", 32'(rdval), 32'b0010);
    check("rd_data",  rd,         32'hDEADBEEF);

    // Byte write merges into an existing word (pointer is at 2 here).
    @(negedge clk); req = 4'b0001; set_ch(1, 0, 0, 4'h0); set_ch(0, 32'h20, 32'h11223344, 4'hF); #1;
    check("bw_full_gnt", 32'(gnt), 32'b0001);
    @(negedge clk); set_ch(0, 32'h20, 32'h00AA0000, 4'b0100); #1;
    check("bw_part_we",   32'(bram_we), 32'b0100);
    check("bw_part_data", bram_wr,      32'h00AA0000);
    @(negedge clk); set_ch(0, 32'h20, 0, 4'h0); #1;
    check("bw_rd_gnt", 32'(gnt), 32'b0001);
    @(negedge clk); req = 4'b0000; #1;
    check("bw_rd_early", 32'(rdval), 32'h0);
    @(negedge clk); #1;
    check("bw_rdval", 32'(rdval), 32'b0001);
    check("bw_data",  rd,         32'h11AA3344);

    // Reads in flight on ch3 and ch0 are dropped by a one-cycle reset.
    // Pointer is 1, so ch3 wins the first cycle.
    @(negedge clk); req = 4'b1001; set_ch(0, 32'h4, 0, 4'h0); set_ch(3, 32'hC, 0, 4'h0); #1;
    check("flt_gnt3", 32'(gnt), 32'b1000);
    @(negedge clk); req = 4'b0001; #1;
    check("flt_gnt0", 32'(gnt), 32'b0001);
    @(negedge clk); req = 4'b0000; rst_n = 1'b0; #1;
    check("flt_rst_rdval", 32'(rdval),    32'h0);
    check("flt_rst_brst",  32'(bram_rst), 32'h1);
    @(negedge clk); rst_n = 1'b1; #1;
    check("flt_drop_a", 32'(rdval),    32'h0);
    check("flt_brst_lo", 32'(bram_rst), 32'h0);
    @(negedge clk); #1;
    check("flt_drop_b", 32'(rdval), 32'h0);
    @(negedge clk); req = 4'b1111; for (int c = 0; c < 4; c++) set_ch(c, 0, 0, 4'h0); #1;
    check("post_rst_first", 32'(gnt), 32'b0001);
    @(negedge clk); req = 4'b0000;
    @(negedge clk); #1;
    check("post_rst_rdval", 32'(rdval), 32'b0001);

`ifdef BRAM_PORT_ARBITER_LOCK_EN
    // Ch1 holds its lock for three grants while the others wait.
    @(negedge clk); req = 4'b0010; lock = 4'b0010; #1;
    check("lk_gnt_a", 32'(gnt), 32'b0010);
    @(negedge clk); req = 4'b1111; #1;
    check("lk_gnt_b", 32'(gnt), 32'b0010);
    @(negedge clk); #1;
    check("lk_gnt_c", 32'(gnt), 32'b0010);
    @(negedge clk); lock = 4'b0000; req = 4'b1101; #1;
    check("lk_rel_2", 32'(gnt), 32'b0100);
    @(negedge clk); req = 4'b1001; #1;
    check("lk_rel_3", 32'(gnt), 32'b1000);
    @(negedge clk); req = 4'b0001; #1;
    check("lk_rel_0", 32'(gnt), 32'b0001);
    @(negedge clk); req = 4'b0000;
    @(negedge clk);
`endif

    // Ch3 alone: 16 writes, then 16 back-to-back reads returned in order.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); req = 4'b1000; set_ch(3, 32'(i * 4), 32'hC0DE0000 + 32'(i), 4'hF); #1;
      check("st_wr_gnt", 32'(gnt), 32'b1000);
    end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i < 16) begin
        req = 4'b1000;
        set_ch(3, 32'(i * 4), 0, 4'h0);
      end else begin
        req = 4'b0000;
      end
      #1;
      if (i < 16) check("st_rd_gnt", 32'(gnt), 32'b1000);
      check("st_rdval", 32'(rdval), (i >= 2) ? 32'b1000 : 32'h0);
      if (i >= 2) check("st_data", rd, 32'hC0DE0000 + 32'(i - 2));
    end
    @(negedge clk); #1;
    check("st_end", 32'(rdval), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter that shares one single-port Block RAM between `NUM_CH` independent requesters. Each channel presents its own enable, address, write data and byte-wise write enable. The arbiter grants one channel per cycle and drives the BRAM port. It tracks every granted read through a latency-matched tag pipeline and returns the read data to its originating channel with a valid pulse. It sits between on-chip masters (DMA, cores, debug) and a BRAM slave port.

## Interface

Parameters:
- `NUM_CH`, 4: number of requesting channels; 2..16.
- `DATA_BITW`, 32: data width in bits; multiple of 8.
- `ADDR_BITW`, 32: byte-address width in bits.
- `RD_LAT`, 1: BRAM read latency in cycles; 1 or 2.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `Clk_CI`  in  1  clock for all logic and for the BRAM port.
- `Rst_RBI`  in  1  synchronous active-low reset.
- `Req_SI`  in  NUM_CH  per-channel access request.
- `Gnt_SO`  out  NUM_CH  one-hot grant, combinational from `Req_SI`.
- `Addr_DI`  in  NUM_CH×ADDR_BITW  per-channel byte address.
- `Wr_DI`  in  NUM_CH×DATA_BITW  per-channel write data.
- `WrEn_SI`  in  NUM_CH×(DATA_BITW/8)  per-channel byte write enable; all-zero means read.
- `Rd_DO`  out  DATA_BITW  read data, shared by all channels.
- `RdVal_SO`  out  NUM_CH  one-hot read-data valid.
- `Bram_Rst_RO`  out  1  BRAM output-register reset, active high; equals `~Rst_RBI`.
- `Bram_En_SO`  out  1  BRAM enable.
- `Bram_Addr_DO`  out  ADDR_BITW  BRAM byte address.
- `Bram_Wr_DO`  out  DATA_BITW  BRAM write data.
- `Bram_WrEn_SO`  out  DATA_BITW/8  BRAM byte write enable.
- `Bram_Rd_DI`  in  DATA_BITW  BRAM read data.

## Operation

- **Arbitration:**
  - The round-robin pointer `Prio_SP` marks the highest-priority channel. Its reset value is 0.
  - The winner is the first requesting channel found by scanning from `Prio_SP` upward, wrapping modulo `NUM_CH`.
  - After each grant, `Prio_SP` becomes `(winner+1) mod NUM_CH`. With no request, `Prio_SP` holds.
- **BRAM drive:**
  - `Bram_En_SO = |Req_SI`.
  - Address, write data and write enable are muxed from the winner.
  - With no grant, address, data and write enable are driven to 0.
- **Write vs. read:**
  - A granted access with a nonzero `WrEn_SI` is a write. It completes in the grant cycle and produces no `RdVal_SO`.
  - A granted access with `WrEn_SI` all-zero is a read.
- **Tag pipeline:**
  - The pipeline is `RD_LAT` stages deep. Each stage holds a valid bit plus a channel index of `$clog2(NUM_CH)` bits.
  - A granted read enters stage 0 at the clock edge.
  - `RdVal_SO` is the one-hot decode of the last stage, gated by its valid bit.
  - `Rd_DO = Bram_Rd_DI` unconditionally.
- **Requester contract:**
  - `Req_SI` must not depend combinationally on `Gnt_SO`.
  - A requester holds `Req_SI` and its request fields stable until it sees its grant.
- **Reset:**
  - All outputs go to 0 during reset, except `Bram_Rst_RO`, which is 1.
  - During reset, `Gnt_SO` is forced to 0 and `Bram_En_SO` is forced to 0.
  - Reset asserted mid-operation clears all pipeline valid bits, so in-flight reads are dropped with no `RdVal_SO`. It also returns `Prio_SP` to 0.

## Timing

- Grant latency is 0 cycles: `Gnt_SO` is valid in the same cycle as `Req_SI`.
- Read latency: a read granted in cycle t gives `RdVal_SO[ch]=1` and valid `Rd_DO` in cycle t+`RD_LAT`.
- Throughput is one access per cycle, with back-to-back reads fully pipelined. `RdVal_SO` can pulse on consecutive cycles for different channels.
- Fairness: under continuous requests from all channels, each channel is granted exactly once every `NUM_CH` cycles.
- A single channel requesting every cycle is granted every cycle.
- A write to address A in cycle t followed by a read of A in cycle t+1 returns the new data. This relies on BRAM write-first or read-after-write ordering across cycles.

## Configuration

Macro `BRAM_PORT_ARBITER_LOCK_EN`:
- **Defined:**
  - An extra input `Lock_SI` (`NUM_CH` bits) is present.
  - If the channel granted in cycle t has both `Req_SI` and `Lock_SI` high in cycle t+1, it is granted again regardless of `Prio_SP`. `Prio_SP` does not advance while the lock is held.
  - The lock ends the first cycle the holder drops `Req_SI` or `Lock_SI`, and normal round-robin resumes from the holder+1.
  - Reset clears the lock.
- **Undefined:**
  - There is no `Lock_SI` port and arbitration is pure round-robin.

## Test plan

- Reset, then `Req_SI=4'b1111` for 8 cycles (NUM_CH=4) -> grants go 0,1,2,3,0,1,2,3.
- Ch2 writes `0xDEADBEEF` to 0x10 with `WrEn_SI=4'hF`, then ch1 reads 0x10 with `RD_LAT=2` -> `RdVal_SO=4'b0010` and `Rd_DO=0xDEADBEEF` exactly 2 cycles after ch1's grant; no `RdVal_SO` for the write.
- Byte write `WrEn_SI=4'b0100` of `0x00AA0000` over `0x11223344`, then read -> `0x11AA3344`.
- Reads in flight on ch0 and ch3 with `RD_LAT=2`; pull `Rst_RBI` low for 1 cycle -> no `RdVal_SO` ever asserted for them, and after reset the first grant goes to ch0.
- Lock build: ch1 is granted with `Lock_SI[1]=1` for 3 cycles while ch0, ch2 and ch3 request -> ch1 is granted 3 times in a row, then ch2 and ch3, then ch0.
- Single-channel stream: ch3 issues 16 back-to-back reads at addresses 0x0..0x3C -> 16 consecutive `RdVal_SO[3]` pulses with the data in order.
